// File: rtl/shadowmask_pkg.sv
// Shared definitions for the shadow-mask config port (loader and video stage).
// Command opcodes, image magic, LUT row pitch and the loader FSM state type.
package shadowmask_pkg;

    typedef enum logic [2:0] {
        OP_IDX_RST = 3'b000,
        OP_VMAX    = 3'b001,
        OP_HMAX    = 3'b010,
        OP_LUT     = 3'b011
    } opcode_e;

    localparam logic [7:0] MASK_MAGIC = 8'hA5;
    localparam int         LUT_ROW    = 16;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR_RD,
        ST_HDR_CHK,
        ST_EMIT_RST,
        ST_EMIT_V,
        ST_EMIT_H,
        ST_LUT_RD,
        ST_LUT_EMIT,
        ST_PAD_EMIT,
        ST_GAP,
        ST_FIN,
        ST_ERR
    } state_e;

    function automatic logic [15:0] mk_cmd(opcode_e op, logic [12:0] payload);
        return {op, payload};
    endfunction

endpackage

// File: rtl/shadowmask_loader.sv
// Reads a packed mask image from slot RAM and emits the shadow-mask command stream.
// Ports: clk_sys/reset_n (sync, active low); start/mask_sel request a load;
//   mem_rd/mem_addr/mem_q slot RAM read port (1-cycle latency);
//   mask_wr/mask_data command stream; busy/done/error load status.
module shadowmask_loader #(
    parameter int ADDR_W      = 12,
    parameter int SEL_W       = 3,
    parameter int SLOT_STRIDE = 512,
    parameter int WR_GAP      = 0
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              start,
    input  logic [SEL_W-1:0]  mask_sel,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_q,
    output logic              mask_wr,
    output logic [15:0]       mask_data,
    output logic              busy,
    output logic              done,
    output logic              error
);
    import shadowmask_pkg::*;

    localparam int GAP_W = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LD = GAP_W'((WR_GAP > 0) ? WR_GAP - 1 : 0);

    state_e            state_q, state_d;
    state_e            ret_q, ret_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [3:0]        h_q, h_d;
    logic [3:0]        v_q, v_d;
    logic [3:0]        vmax_q, vmax_d;
    logic [3:0]        hmax_q, hmax_d;
    logic [15:0]       data_q;

    logic [ADDR_W-1:0] base;
    logic [15:0]       cmd;
    state_e            after;
    state_e            slot_nx;
    logic [3:0]        h_nx;
    logic              row_end;

    assign base = ADDR_W'(mask_sel) * ADDR_W'(SLOT_STRIDE);

    // Next column wraps naturally in 4 bits; column 0 always holds an entry.
    assign h_nx    = h_q + 4'd1;
    assign row_end = (h_q == 4'(LUT_ROW - 1));
    assign slot_nx = (h_nx <= hmax_q) ? ST_LUT_RD : ST_PAD_EMIT;

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        gap_d   = gap_q;
        ptr_d   = ptr_q;
        h_d     = h_q;
        v_d     = v_q;
        vmax_d  = vmax_q;
        hmax_d  = hmax_q;
        mem_rd  = 1'b0;
        mask_wr = 1'b0;
        done    = 1'b0;
        error   = 1'b0;
        cmd     = 16'h0000;
        after   = ST_IDLE;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_HDR_RD;
                    ptr_d   = base;
                end
            end
            ST_HDR_RD: begin
                mem_rd  = 1'b1;
                ptr_d   = ptr_q + ADDR_W'(1);
                state_d = ST_HDR_CHK;
            end
            ST_HDR_CHK: begin
                if (mem_q[15:8] == MASK_MAGIC) begin
                    vmax_d  = mem_q[7:4];
                    hmax_d  = mem_q[3:0];
                    h_d     = 4'd0;
                    v_d     = 4'd0;
                    state_d = ST_EMIT_RST;
                end else begin
                    state_d = ST_ERR;
                end
            end
            ST_EMIT_RST: begin
                mask_wr = 1'b1;
                cmd     = mk_cmd(OP_IDX_RST, 13'd0);
                after   = ST_EMIT_V;
            end
            ST_EMIT_V: begin
                mask_wr = 1'b1;
                cmd     = mk_cmd(OP_VMAX, {9'd0, vmax_q});
                after   = ST_EMIT_H;
            end
            ST_EMIT_H: begin
                mask_wr = 1'b1;
                cmd     = mk_cmd(OP_HMAX, {9'd0, hmax_q});
                after   = ST_LUT_RD;
            end
            ST_LUT_RD: begin
                mem_rd  = 1'b1;
                ptr_d   = ptr_q + ADDR_W'(1);
                state_d = ST_LUT_EMIT;
            end
            ST_LUT_EMIT, ST_PAD_EMIT: begin
                mask_wr = 1'b1;
                cmd     = mk_cmd(OP_LUT, (state_q == ST_LUT_EMIT) ?
                                 {2'b00, mem_q[10:0]} : 13'd0);
                h_d     = h_nx;
                if (row_end) begin
                    v_d = v_q + 4'd1;
                end
                after = (row_end && (v_q == vmax_q)) ? ST_FIN : slot_nx;
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ret_q;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            ST_FIN: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                error   = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Every command write is followed by the enforced idle gap.
        if (mask_wr) begin
            if (WR_GAP > 0) begin
                state_d = ST_GAP;
                ret_d   = after;
                gap_d   = GAP_LD;
            end else begin
                state_d = after;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ret_q   <= ST_IDLE;
            gap_q   <= '0;
            ptr_q   <= '0;
            h_q     <= 4'd0;
            v_q     <= 4'd0;
            vmax_q  <= 4'd0;
            hmax_q  <= 4'd0;
            data_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            gap_q   <= gap_d;
            ptr_q   <= ptr_d;
            h_q     <= h_d;
            v_q     <= v_d;
            vmax_q  <= vmax_d;
            hmax_q  <= hmax_d;
            if (mask_wr) begin
                data_q <= cmd;
            end
        end
    end

    assign mem_addr  = mem_rd ? ptr_q : '0;
    assign mask_data = mask_wr ? cmd : data_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_shadowmask_loader.sv
// Self-checking bench for shadowmask_loader: directed table, random loads,
// ignored starts and mid-load reset, against a stream-level reference model.
module tb_shadowmask_loader;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [1:0]       start_w = '0;
    logic [1:0][2:0]  sel_w = '0;
    logic [1:0]       rd_w, wr_w, busy_w, done_w, err_w;
    logic [1:0][11:0] addr_w;
    logic [1:0][15:0] data_w;
    logic [15:0]      q_w [2];
    logic [15:0]      ram [4096];

    int cyc = 0;
    int cur = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int bcnt;

    logic [15:0] wq[$];
    int          wt[$];
    int          rq[$];
    int          dq[$];
    int          eq[$];

    logic [15:0] ew[$];
    int          et[$];
    int          er[$];
    bit          e_err;
    int          e_end;
    int          e_busy;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        shadowmask_loader #(.WR_GAP(2 * g)) u_dut (
            .clk_sys  (clk),
            .reset_n  (reset_n),
            .start    (start_w[g]),
            .mask_sel (sel_w[g]),
            .mem_rd   (rd_w[g]),
            .mem_addr (addr_w[g]),
            .mem_q    (q_w[g]),
            .mask_wr  (wr_w[g]),
            .mask_data(data_w[g]),
            .busy     (busy_w[g]),
            .done     (done_w[g]),
            .error    (err_w[g])
        );
    end

    // RAM returns data one cycle after a read; garbage otherwise.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int g = 0; g < 2; g++) begin
            q_w[g] <= rd_w[g] ? ram[addr_w[g]] : 16'hDEAD;
        end
    end

    always @(negedge clk) begin
        if (wr_w[cur]) begin
            wq.push_back(data_w[cur]);
            wt.push_back(cyc);
        end
        if (rd_w[cur]) rq.push_back(32'(addr_w[cur]));
        if (done_w[cur]) dq.push_back(cyc);
        if (err_w[cur]) eq.push_back(cyc);
        if (busy_w[cur]) bcnt++;
    end

    task automatic cmp(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clr();
        wq.delete(); wt.delete(); rq.delete();
        dq.delete(); eq.delete();
        bcnt = 0;
    endtask

    // Expected stream built from the image rules: header, then 16 slots
    // per row, reads at base+1+v*(hmax+1)+h, 2 cycles per entry, 1 per pad.
    task automatic model(input int s, input int gap, input int acc);
        int base, nv, nh, t, a;
        logic [15:0] hdr;
        ew.delete(); et.delete(); er.delete();
        base = (s * 512) % 4096;
        hdr = ram[12'(base)];
        er.push_back(base);
        if (hdr[15:8] != 8'hA5) begin
            e_err = 1; e_end = acc + 3; e_busy = 3;
            return;
        end
        e_err = 0;
        nv = int'(hdr[7:4]) + 1;
        nh = int'(hdr[3:0]) + 1;
        t = acc + 3;
        ew.push_back(16'h0000); et.push_back(t); t += 1 + gap;
        ew.push_back(16'h2000 | 16'(hdr[7:4])); et.push_back(t); t += 1 + gap;
        ew.push_back(16'h4000 | 16'(hdr[3:0])); et.push_back(t); t += 1 + gap;
        for (int v = 0; v < nv; v++) begin
            for (int h = 0; h < 16; h++) begin
                if (h < nh) begin
                    a = (base + 1 + v * nh + h) % 4096;
                    er.push_back(a);
                    ew.push_back(16'h6000 | (ram[12'(a)] & 16'h07FF));
                    et.push_back(t + 1);
                    t += 2 + gap;
                end else begin
                    ew.push_back(16'h6000);
                    et.push_back(t);
                    t += 1 + gap;
                end
            end
        end
        e_end = t;
        e_busy = t - acc;
    endtask

    // mode 0: plain load; 1: extra starts while busy and in done cycle;
    // 2: reset mid-LUT phase, check outputs cleared, abandon.
    task automatic load(input int g, input int s, input int mode);
        int acc, gap, minsp, n;
        bit fin;
        gap = 2 * g;
        cur = g;
        clr();
        @(negedge clk); #1;
        acc = cyc;
        model(s, gap, acc);
        start_w[g] = 1'b1;
        sel_w[g] = 3'(s);
        fin = 0;
        for (int k = 0; k < 6000 && !fin; k++) begin
            @(negedge clk); #1;
            start_w = '0;
            if (mode == 1 && (cyc == acc + 5 || cyc == acc + 9 || cyc == e_end)) begin
                start_w[g] = 1'b1;
                sel_w[g] = 3'd7;
            end
            if (mode == 2 && cyc == acc + 20) begin
                reset_n = 1'b0;
                @(negedge clk); #1;
                cmp("rst_ctl", 32'({rd_w[g], wr_w[g], busy_w[g], done_w[g], err_w[g]}), 0);
                cmp("rst_addr", 32'(addr_w[g]), 0);
                cmp("rst_data", 32'(data_w[g]), 0);
                reset_n = 1'b1;
                return;
            end
            if (dq.size() + eq.size() > 0) fin = 1;
        end
        repeat (6) begin
            @(negedge clk); #1;
            start_w = '0;
        end
        if (!fin) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout: load sel %0d never finished", s);
        end
        cmp("nwr", wq.size(), ew.size());
        n = (wq.size() < ew.size()) ? wq.size() : ew.size();
        for (int i = 0; i < n; i++) begin
            cmp($sformatf("wr%0d_data", i), 32'(wq[i]), 32'(ew[i]));
            cmp($sformatf("wr%0d_cyc", i), wt[i] - acc, et[i] - acc);
        end
        cmp("nrd", rq.size(), er.size());
        n = (rq.size() < er.size()) ? rq.size() : er.size();
        for (int i = 0; i < n; i++) cmp($sformatf("rd%0d_addr", i), rq[i], er[i]);
        cmp("ndone", dq.size(), e_err ? 0 : 1);
        cmp("nerr", eq.size(), e_err ? 1 : 0);
        if (dq.size() > 0) cmp("done_cyc", dq[0] - acc, e_end - acc);
        if (eq.size() > 0) cmp("err_cyc", eq[0] - acc, e_end - acc);
        cmp("busy_cycles", bcnt, e_busy);
        if (wt.size() > 1) begin
            minsp = 1000;
            for (int i = 1; i < wt.size(); i++)
                if (wt[i] - wt[i-1] < minsp) minsp = wt[i] - wt[i-1];
            cmp("min_spacing_ok", 32'(minsp >= 1 + gap), 1);
        end
        if (!e_err && ew.size() > 0) cmp("data_hold", 32'(data_w[g]), 32'(ew[ew.size()-1]));
    endtask

    typedef struct {
        int          sel;
        int          g;
        logic [15:0] hdr;
        int          mode;
        int          nwr;
        int          nerr;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int s, base, nv, nh;
        logic [7:0] mg;
        tbl[0] = '{0, 0, 16'hA511, 0, 35, 0};
        tbl[1] = '{1, 0, 16'h1234, 0, 0, 1};
        tbl[2] = '{2, 0, 16'hA500, 0, 19, 0};
        tbl[3] = '{3, 1, 16'hA5FF, 0, 259, 0};
        tbl[4] = '{0, 0, 16'hA511, 1, 35, 0};
        tbl[5] = '{5, 1, 16'hA523, 1, 51, 0};

        for (int i = 0; i < 4096; i++) ram[i] = 16'($urandom);
        ram[1] = 16'hF70F; ram[2] = 16'h000C;
        ram[3] = 16'h080C; ram[4] = 16'h070F;
        ram[1025] = 16'h0501;

        repeat (3) @(negedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            cmp("reset_ctl", 32'({rd_w[g], wr_w[g], busy_w[g], done_w[g], err_w[g]}), 0);
            cmp("reset_data", 32'({addr_w[g], data_w[g]}), 0);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            ram[tbl[i].sel * 512] = tbl[i].hdr;
            load(tbl[i].g, tbl[i].sel, tbl[i].mode);
            cmp("tbl_nwr", wq.size(), tbl[i].nwr);
            cmp("tbl_nerr", eq.size(), tbl[i].nerr);
        end

        for (int it = 0; it < 10; it++) begin
            s = $urandom_range(0, 7);
            base = s * 512;
            nv = $urandom_range(0, 15);
            nh = $urandom_range(0, 15);
            mg = 8'hA5;
            if ($urandom_range(0, 3) == 0) begin
                mg = 8'($urandom);
                if (mg == 8'hA5) mg = 8'h5A;
            end
            ram[base] = {mg, 4'(nv), 4'(nh)};
            for (int i = 1; i < 512; i++) ram[base + i] = 16'($urandom);
            load($urandom_range(0, 1), s, 0);
        end

        ram[0] = 16'hA533;
        load(0, 0, 2);
        repeat (2) @(negedge clk);
        load(0, 0, 0);
        cmp("reload_nwr", wq.size(), 67);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
